// File: rtl/conv_layer_pkg.sv
// Shared constants, state encoding and tap-index helper for the 3x3 convolution layer.
package conv_layer_pkg;

  localparam int IMAGE_SIZE  = 8;
  localparam int KERNEL_SIZE = 3;
  localparam int ARRAY_SIZE  = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int TAP_COUNT   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ADDR_WIDTH  = 6;
  localparam int WADDR_WIDTH = 4;
  localparam int KIDX_WIDTH  = 2;
  localparam int ROW_WIDTH   = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [WADDR_WIDTH-1:0] tap_index(input logic [KIDX_WIDTH-1:0] kr,
                                                       input logic [KIDX_WIDTH-1:0] kc);
    return WADDR_WIDTH'(kr) * WADDR_WIDTH'(KERNEL_SIZE) + WADDR_WIDTH'(kc);
  endfunction

endpackage

// File: rtl/conv_tap_counter.sv
// Nested row / kernel-row / kernel-column counter for the convolution schedule.
module conv_tap_counter
  import conv_layer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  step_i,
  input  logic                  row_inc_i,
  output logic [KIDX_WIDTH-1:0] kr_o,
  output logic [KIDX_WIDTH-1:0] kc_o,
  output logic [ROW_WIDTH-1:0]  row_o,
  output logic                  last_tap_o,
  output logic                  last_row_o
);

  logic [KIDX_WIDTH-1:0] kr_q, kr_d, kc_q, kc_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;

  localparam logic [KIDX_WIDTH-1:0] KMAX = KIDX_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [ROW_WIDTH-1:0]  RMAX = ROW_WIDTH'(ARRAY_SIZE - 1);

  // Clear has priority over a row advance, which has priority over a tap step.
  always_comb begin
    kr_d  = kr_q;
    kc_d  = kc_q;
    row_d = row_q;
    if (clear_i) begin
      kr_d  = '0;
      kc_d  = '0;
      row_d = '0;
    end else if (row_inc_i) begin
      kr_d  = '0;
      kc_d  = '0;
      row_d = row_q + 1'b1;
    end else if (step_i) begin
      if (kc_q == KMAX) begin
        kc_d = '0;
        kr_d = (kr_q == KMAX) ? '0 : kr_q + 1'b1;
      end else begin
        kc_d = kc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kr_q  <= '0;
      kc_q  <= '0;
      row_q <= '0;
    end else begin
      kr_q  <= kr_d;
      kc_q  <= kc_d;
      row_q <= row_d;
    end
  end

  assign kr_o       = kr_q;
  assign kc_o       = kc_q;
  assign row_o      = row_q;
  assign last_tap_o = (kr_q == KMAX) && (kc_q == KMAX);
  assign last_row_o = (row_q == RMAX);

endmodule

// File: rtl/conv_layer_scheduler.sv
// Stallable sequencer issuing ROM addresses and accumulate controls for the 3x3 kernel array,
// presenting each finished output row on a valid/ready handshake.
module conv_layer_scheduler
  import conv_layer_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   enable_i,
  output logic [ADDR_WIDTH-1:0]  img_rom_addr_o,
  output logic [WADDR_WIDTH-1:0] weight_rom_addr_o,
  output logic                   acc_clr_o,
  output logic                   acc_en_o,
  output logic                   row_valid_o,
  input  logic                   row_ready_i,
  output logic [2:0]             row_idx_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [2:0]             current_state_o
);

  state_e state_q, state_d;
  logic   acc_en_q, acc_en_d, acc_clr_q, acc_clr_d;
  logic   cnt_clear, cnt_step, cnt_row_inc;
  logic   last_tap, last_row;
  logic [KIDX_WIDTH-1:0] kr, kc;
  logic [ROW_WIDTH-1:0]  row;

  conv_tap_counter u_tap_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (cnt_clear),
    .step_i     (cnt_step),
    .row_inc_i  (cnt_row_inc),
    .kr_o       (kr),
    .kc_o       (kc),
    .row_o      (row),
    .last_tap_o (last_tap),
    .last_row_o (last_row)
  );

  always_comb begin
    state_d     = state_q;
    cnt_clear   = 1'b0;
    cnt_step    = 1'b0;
    cnt_row_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_clear = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (enable_i) begin
          cnt_step = 1'b1;
          if (last_tap) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT: begin
        if (row_ready_i) begin
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            cnt_row_inc = 1'b1;
            state_d     = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // ROM data arrives one cycle after the tap is issued, so the accumulate strobes lag by one.
    acc_en_d  = cnt_step;
    acc_clr_d = cnt_step && (kr == '0) && (kc == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_en_q  <= acc_en_d;
      acc_clr_q <= acc_clr_d;
    end
  end

  always_comb begin
    img_rom_addr_o    = '0;
    weight_rom_addr_o = '0;
    if (state_q == ST_LOAD) begin
      img_rom_addr_o    = (ADDR_WIDTH'(row) + ADDR_WIDTH'(kr)) * ADDR_WIDTH'(IMAGE_SIZE)
                          + ADDR_WIDTH'(kc);
      weight_rom_addr_o = tap_index(kr, kc);
    end
  end

  assign acc_en_o        = acc_en_q;
  assign acc_clr_o       = acc_clr_q;
  assign row_valid_o     = (state_q == ST_OUT);
  assign row_idx_o       = (state_q == ST_OUT) ? row : 3'd0;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);
  assign current_state_o = state_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler; cycle n is the interval following rising edge n-1,
// with the start pulse sampled at edge 0.
module tb_conv_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b1;
  logic       rowReady = 1'b1;
  logic [5:0] imgAddr;
  logic [3:0] weightAddr;
  logic       accClr, accEn, rowValid, busy, done;
  logic [2:0] rowIdx, curState;

  int tests = 0;
  int fails = 0;
  int imgTbl[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

  always #5 clk = ~clk;

  conv_layer_scheduler dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .enable_i          (enable),
    .img_rom_addr_o    (imgAddr),
    .weight_rom_addr_o (weightAddr),
    .acc_clr_o         (accClr),
    .acc_en_o          (accEn),
    .row_valid_o       (rowValid),
    .row_ready_i       (rowReady),
    .row_idx_o         (rowIdx),
    .busy_o            (busy),
    .done_o            (done),
    .current_state_o   (curState)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; start = 1'b0; enable = 1'b1; rowReady = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    tests++;
    if ({curState, busy, done, rowValid, accEn, accClr, imgAddr, weightAddr, rowIdx} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: state=%0d busy=%0b done=%0b valid=%0b en=%0b clr=%0b img=%0d w=%0d idx=%0d, want all 0",
               curState, busy, done, rowValid, accEn, accClr, imgAddr, weightAddr, rowIdx);
    end
  endtask

  task automatic test_frame();
    int rowsSeen = 0, accCount = 0, clrCount = 0;
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 69; c++) begin
      int r = (c - 1) / 11;
      int t = (c - 1) % 11;
      if (c <= 66 && t <= 8) begin
        tests++;
        if (weightAddr !== 4'(t)) begin
          fails++; $display("[TB] FAIL frame_waddr c=%0d: got %0d want %0d", c, weightAddr, t);
        end
        tests++;
        if (imgAddr !== 6'(r * 8 + imgTbl[t])) begin
          fails++; $display("[TB] FAIL frame_iaddr c=%0d: got %0d want %0d", c, imgAddr, r * 8 + imgTbl[t]);
        end
      end
      tests++;
      if (rowValid !== (c <= 66 && t == 10)) begin
        fails++; $display("[TB] FAIL frame_valid c=%0d: got %0b want %0b", c, rowValid, (c <= 66 && t == 10));
      end
      if (rowValid === 1'b1) begin
        tests++;
        if (rowIdx !== 3'(rowsSeen)) begin
          fails++; $display("[TB] FAIL frame_rowidx c=%0d: got %0d want %0d", c, rowIdx, rowsSeen);
        end
        rowsSeen++;
      end
      tests++;
      if (accEn !== (c <= 66 && t >= 1 && t <= 9)) begin
        fails++; $display("[TB] FAIL frame_accen c=%0d: got %0b want %0b", c, accEn, (c <= 66 && t >= 1 && t <= 9));
      end
      tests++;
      if (accClr !== (c <= 66 && t == 1)) begin
        fails++; $display("[TB] FAIL frame_accclr c=%0d: got %0b want %0b", c, accClr, (c <= 66 && t == 1));
      end
      tests++;
      if (done !== (c == 67) || busy !== (c <= 67)) begin
        fails++; $display("[TB] FAIL frame_done_busy c=%0d: got done=%0b busy=%0b want done=%0b busy=%0b",
                          c, done, busy, (c == 67), (c <= 67));
      end
      if (accEn === 1'b1) accCount++;
      if (accClr === 1'b1) clrCount++;
      tick();
    end
    tests++;
    if (rowsSeen != 6 || accCount != 54 || clrCount != 6) begin
      fails++; $display("[TB] FAIL frame_counts: rows=%0d en=%0d clr=%0d want 6 54 6", rowsSeen, accCount, clrCount);
    end
  endtask

  task automatic test_enable_pause();
    int accCount = 0, clrCount = 0;
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      int tk = (c <= 5) ? c - 1 : ((c <= 8) ? 4 : c - 4);
      logic expEn = (c >= 2 && c <= 5) || (c >= 9 && c <= 13);
      enable = !((c >= 5 && c <= 7) || c == 13 || c == 14);
      if (c <= 12) begin
        tests++;
        if (weightAddr !== 4'(tk) || imgAddr !== 6'(imgTbl[tk])) begin
          fails++; $display("[TB] FAIL pause_addr c=%0d: got w=%0d img=%0d want w=%0d img=%0d",
                            c, weightAddr, imgAddr, tk, imgTbl[tk]);
        end
      end
      tests++;
      if (accEn !== expEn) begin
        fails++; $display("[TB] FAIL pause_accen c=%0d: got %0b want %0b", c, accEn, expEn);
      end
      tests++;
      if (rowValid !== (c == 14)) begin
        fails++; $display("[TB] FAIL pause_valid c=%0d: got %0b want %0b", c, rowValid, (c == 14));
      end
      if (c == 15) begin
        tests++;
        if (curState !== 3'd1 || imgAddr !== 6'd8) begin
          fails++; $display("[TB] FAIL pause_next_row: got state=%0d img=%0d want 1 8", curState, imgAddr);
        end
      end
      if (accEn === 1'b1) accCount++;
      if (accClr === 1'b1) clrCount++;
      tick();
    end
    enable = 1'b1;
    tests++;
    if (accCount != 9 || clrCount != 1) begin
      fails++; $display("[TB] FAIL pause_counts: en=%0d clr=%0d want 9 1", accCount, clrCount);
    end
  endtask

  task automatic test_ready_stall();
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      rowReady = !(c >= 11 && c <= 15);
      if (c >= 11 && c <= 16) begin
        tests++;
        if (rowValid !== 1'b1 || rowIdx !== 3'd0 || accEn !== 1'b0 || curState !== 3'd3) begin
          fails++; $display("[TB] FAIL stall_hold c=%0d: got valid=%0b idx=%0d en=%0b state=%0d want 1 0 0 3",
                            c, rowValid, rowIdx, accEn, curState);
        end
      end
      if (c == 17) begin
        tests++;
        if (curState !== 3'd1 || imgAddr !== 6'd8 || weightAddr !== 4'd0) begin
          fails++; $display("[TB] FAIL stall_resume: got state=%0d img=%0d w=%0d want 1 8 0", curState, imgAddr, weightAddr);
        end
      end
      if (c == 18) begin
        tests++;
        if (accEn !== 1'b1 || accClr !== 1'b1 || imgAddr !== 6'd9 || weightAddr !== 4'd1) begin
          fails++; $display("[TB] FAIL stall_first_tap: got en=%0b clr=%0b img=%0d w=%0d want 1 1 9 1",
                            accEn, accClr, imgAddr, weightAddr);
        end
      end
      tick();
    end
    rowReady = 1'b1;
  endtask

  task automatic test_reset_mid();
    doReset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 36; c++) tick();
    tests++;
    if (curState !== 3'd1 || imgAddr !== 6'd32 || weightAddr !== 4'd3) begin
      fails++; $display("[TB] FAIL midrst_before: got state=%0d img=%0d w=%0d want 1 32 3", curState, imgAddr, weightAddr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({curState, busy, done, rowValid, accEn, accClr, imgAddr, weightAddr, rowIdx} !== '0) begin
      fails++; $display("[TB] FAIL midrst_after: state=%0d busy=%0b en=%0b img=%0d w=%0d, want all 0",
                        curState, busy, accEn, imgAddr, weightAddr);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (curState !== 3'd1 || imgAddr !== 6'd0 || weightAddr !== 4'd0 || busy !== 1'b1) begin
      fails++; $display("[TB] FAIL midrst_restart: got state=%0d img=%0d w=%0d busy=%0b want 1 0 0 1",
                        curState, imgAddr, weightAddr, busy);
    end
    tick();
    tests++;
    if (accClr !== 1'b1 || accEn !== 1'b1) begin
      fails++; $display("[TB] FAIL midrst_clr: got clr=%0b en=%0b want 1 1", accClr, accEn);
    end
  endtask

  task automatic test_start_conflicts();
    doReset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    tests++;
    if (curState !== 3'd0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL start_with_rst: got state=%0d busy=%0b want 0 0", curState, busy);
    end
    tick();
    tests++;
    if (curState !== 3'd0) begin
      fails++; $display("[TB] FAIL start_with_rst_after: got state=%0d want 0", curState);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 69; c++) begin
      start = (c == 5 || c == 11 || c == 40 || c == 67);
      if (c == 12) begin
        tests++;
        if (curState !== 3'd1 || imgAddr !== 6'd8) begin
          fails++; $display("[TB] FAIL busy_start_row1: got state=%0d img=%0d want 1 8", curState, imgAddr);
        end
      end
      if (c == 66) begin
        tests++;
        if (rowValid !== 1'b1 || rowIdx !== 3'd5) begin
          fails++; $display("[TB] FAIL busy_start_row5: got valid=%0b idx=%0d want 1 5", rowValid, rowIdx);
        end
      end
      tests++;
      if (done !== (c == 67)) begin
        fails++; $display("[TB] FAIL busy_start_done c=%0d: got %0b want %0b", c, done, (c == 67));
      end
      if (c >= 68) begin
        tests++;
        if (curState !== 3'd0 || busy !== 1'b0) begin
          fails++; $display("[TB] FAIL busy_start_idle c=%0d: got state=%0d busy=%0b want 0 0", c, curState, busy);
        end
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_enable_pause();
    test_ready_stall();
    test_reset_mid();
    test_start_conflicts();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
